// File: rtl/prince_sbox_cms_compress.sv
// Purpose: register-isolate the expanded CMS S-box output shares, then compress them
//          to NUM_OUT_SHARES shares and refresh them with fresh random nibbles.
// Latency: 2 cycles from accept to out_valid, 1 transfer/cycle; stalls hold both stages.
module prince_sbox_cms_compress #(
    parameter int NUM_IN_SHARES  = 4,
    parameter int NUM_OUT_SHARES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [4*NUM_IN_SHARES-1:0]      in_shares,
    input  logic [4*(NUM_OUT_SHARES-1)-1:0] rand_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [4*NUM_OUT_SHARES-1:0]     out_shares
);

    localparam int IW = 4 * NUM_IN_SHARES;
    localparam int RW = 4 * (NUM_OUT_SHARES - 1);
    localparam int OW = 4 * NUM_OUT_SHARES;

    // Stage 1: the isolation register. Each nibble stays in its own flops; no share
    // of one domain may meet a share of another before this point.
    logic              s1_valid_q, s1_valid_d;
    (* keep = "true" *) logic [IW-1:0] s1_shares_q;
    logic [IW-1:0]     s1_shares_d;
    (* keep = "true" *) logic [RW-1:0] s1_rand_q;
    logic [RW-1:0]     s1_rand_d;

    // Stage 2: compressed and refreshed shares driving the output stream.
    logic              s2_valid_q, s2_valid_d;
    (* keep = "true" *) logic [OW-1:0] s2_shares_q;
    logic [OW-1:0]     s2_shares_d;

    logic              adv2;
    logic              accept;
    logic [OW-1:0]     comp_dat;
    logic [3:0]        rand_sum;

    // Handshake: stage 1 frees up whenever its content moves on, so in_ready only
    // depends on local state and out_ready.
    always_comb begin
        adv2     = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = !s1_valid_q || adv2;
        accept   = in_valid && in_ready;
    end

    // Stage-1 next state: load raw shares and randomness unmodified on accept.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_shares_d = s1_shares_q;
        s1_rand_d   = s1_rand_q;
        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_shares_d = in_shares;
            s1_rand_d   = rand_in;
        end else if (adv2) begin
            s1_valid_d  = 1'b0;
        end
    end

    // Compression: fold nibble i into output share (i mod NUM_OUT_SHARES), mask each
    // non-last share with its own random nibble and the last with the sum of all of
    // them, so the unmasked XOR of the outputs equals that of the inputs.
    always_comb begin
        comp_dat = '0;
        rand_sum = '0;
        for (int i = 0; i < NUM_IN_SHARES; i++) begin
            comp_dat[(i % NUM_OUT_SHARES)*4 +: 4] =
                comp_dat[(i % NUM_OUT_SHARES)*4 +: 4] ^ s1_shares_q[i*4 +: 4];
        end
        for (int j = 0; j < NUM_OUT_SHARES - 1; j++) begin
            comp_dat[j*4 +: 4] = comp_dat[j*4 +: 4] ^ s1_rand_q[j*4 +: 4];
            rand_sum           = rand_sum ^ s1_rand_q[j*4 +: 4];
        end
        comp_dat[(NUM_OUT_SHARES-1)*4 +: 4] = comp_dat[(NUM_OUT_SHARES-1)*4 +: 4] ^ rand_sum;
    end

    // Stage-2 next state: reload on advance, drain on out_ready, hold while stalled.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_shares_d = s2_shares_q;
        if (adv2) begin
            s2_valid_d  = 1'b1;
            s2_shares_d = comp_dat;
        end else if (out_ready) begin
            s2_valid_d  = 1'b0;
        end
    end

    // State registers; reset drops all in-flight data and zeroes the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_shares_q <= '0;
            s1_rand_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_shares_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_shares_q <= s1_shares_d;
            s1_rand_q   <= s1_rand_d;
            s2_valid_q  <= s2_valid_d;
            s2_shares_q <= s2_shares_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_shares = s2_shares_q;

endmodule

// File: tb/tb_prince_sbox_cms_compress.sv
// Purpose: self-checking bench for prince_sbox_cms_compress with a scoreboard queue.
// Latency: checks 2-cycle accept-to-output timing and back-to-back streaming.
// Backpressure: stalls out_ready, checks output stability and in_ready deassertion.
module tb_prince_sbox_cms_compress;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_shares;
    logic [3:0]  rand_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_shares;

    prince_sbox_cms_compress #(.NUM_IN_SHARES(4), .NUM_OUT_SHARES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_shares  (in_shares),
        .rand_in    (rand_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_shares (out_shares)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] in_dat;
        logic [3:0]  rnd;
        logic [7:0]  exp_out;
        logic [3:0]  exp_unm;
    } vec_t;

    typedef struct {
        logic [7:0] out_dat;
        logic [3:0] unm;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] got_q[$];
    int         popcyc_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         acc_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] model(input logic [15:0] d, input logic [3:0] r);
        logic [3:0] c0, c1;
        c0 = d[3:0] ^ d[11:8];
        c1 = d[7:4] ^ d[15:12];
        return {c1 ^ r, c0 ^ r};
    endfunction

    // Drive one transfer and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [15:0] d, input logic [3:0] r, input logic [7:0] e,
                        input logic [3:0] u);
        bit   acc;
        int   guard;
        exp_t x;
        acc   = 1'b0;
        guard = 0;
        in_valid  = 1'b1;
        in_shares = d;
        rand_in   = r;
        while (!acc) begin
            @(negedge clk);
            acc     = in_ready;
            acc_cyc = cyc;
            if (acc) begin
                x.out_dat = e;
                x.unm     = u;
                exp_q.push_back(x);
            end
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 200) begin
                chk("accept_timeout", 32'd1, 32'd0);
                acc = 1'b1;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every transfer and checks stall stability.
    bit         prev_stall = 1'b0;
    logic [7:0] prev_out;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid_hold", out_valid, 1);
                    chk("stall_data_hold", out_shares, prev_out);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL spurious_output: got %0h required none", out_shares);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_shares", out_shares, e.out_dat);
                        chk("unmasked", out_shares[3:0] ^ out_shares[7:4], e.unm);
                        got_q.push_back(out_shares);
                        popcyc_q.push_back(cyc);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = out_shares;
            end
        end
    end

    logic [3:0] sbox [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                              4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

    task automatic send_sbox_stream();
        logic [3:0]  n0, n1, n2, n3, r;
        logic [15:0] d;
        for (int x = 0; x < 16; x++) begin
            n0 = 4'($urandom_range(0, 15));
            n1 = 4'($urandom_range(0, 15));
            n2 = 4'($urandom_range(0, 15));
            n3 = sbox[x] ^ n0 ^ n1 ^ n2;
            r  = 4'($urandom_range(0, 15));
            d  = {n3, n2, n1, n0};
            send(d, r, model(d, r), sbox[x]);
        end
        idle();
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = '{16'h2953, 4'h6, 8'h1C, 4'hD};
        tbl[1] = '{16'h2953, 4'h0, 8'h7A, 4'hD};
        tbl[2] = '{16'h2953, 4'hF, 8'h85, 4'hD};
        tbl[3] = '{16'hFFFF, 4'h0, 8'h00, 4'h0};
        tbl[4] = '{16'h1234, 4'h5, 8'h73, 4'h4};
        tbl[5] = '{16'h0001, 4'hA, 8'hAB, 4'h1};
        tbl[6] = '{16'h8421, 4'h3, 8'h96, 4'hF};

        // Reset held for two cycles with in_valid asserted.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_shares = 16'hABCD;
        rand_in   = 4'h7;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset_out_valid", out_valid, 0);
            chk("reset_out_shares", out_shares, 0);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_idle_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // Single transfer, latency measured from the accept cycle.
        got_q.delete();
        popcyc_q.delete();
        send(tbl[0].in_dat, tbl[0].rnd, tbl[0].exp_out, tbl[0].exp_unm);
        idle();
        drain();
        chk("single_count", got_q.size(), 1);
        if (popcyc_q.size() == 1) chk("single_latency", popcyc_q[0] - acc_cyc, 2);

        // Table vectors sent back-to-back.
        got_q.delete();
        for (int i = 0; i < 7; i++) send(tbl[i].in_dat, tbl[i].rnd, tbl[i].exp_out, tbl[i].exp_unm);
        idle();
        drain();
        chk("table_count", got_q.size(), 7);
        if (got_q.size() == 7) chk("rand_indep_diff", got_q[1] ^ got_q[2], 8'hFF);

        // Streaming S-box outputs with full throughput.
        got_q.delete();
        popcyc_q.delete();
        send_sbox_stream();
        drain();
        chk("stream_count", got_q.size(), 16);
        if (popcyc_q.size() == 16) chk("stream_back_to_back", popcyc_q[15] - popcyc_q[0], 15);

        // Same stream with a 5-cycle out_ready stall in the middle.
        got_q.delete();
        fork
            send_sbox_stream();
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                chk("stall_in_ready_low", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_stream_count", got_q.size(), 16);

        // Reset with both stages full; flushed data must never appear.
        out_ready = 1'b0;
        send(16'h5555, 4'h1, 8'h00, 4'h0);
        send(16'h6666, 4'h2, 8'h00, 4'h0);
        idle();
        @(negedge clk);
        chk("full_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_out_shares", out_shares, 0);
        chk("midreset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        got_q.delete();
        send(tbl[4].in_dat, tbl[4].rnd, tbl[4].exp_out, tbl[4].exp_unm);
        idle();
        drain();
        repeat (5) @(posedge clk);
        chk("post_reset_count", got_q.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
